// File: rtl/layer_compositor_ctrl_if.sv
// Pixel-path and configuration signals between game logic / video timing and the
// layer compositor front-end.
interface layer_compositor_ctrl_if #(
  parameter int N  = 8,
  parameter int BW = 4
);
  logic          tick;
  logic          video_on;
  logic          frame_start;
  logic [N-1:0]  on_in;
  logic [N-1:0]  r_in;
  logic [N-1:0]  g_in;
  logic [N-1:0]  b_in;
  logic [N-1:0]  on_out;
  logic [N-1:0]  r_out;
  logic [N-1:0]  g_out;
  logic [N-1:0]  b_out;
  logic          video_on_out;
  logic          cfg_req;
  logic [N-1:0]  cfg_en_mask;
  logic [N-1:0]  cfg_blink_mask;
  logic [BW-1:0] cfg_blink_period;
  logic          cfg_ack;
  logic          cfg_pending;
  logic [N-1:0]  collide;
  logic          collide_valid;

  modport master (
    output tick, video_on, frame_start, on_in, r_in, g_in, b_in,
           cfg_req, cfg_en_mask, cfg_blink_mask, cfg_blink_period,
    input  on_out, r_out, g_out, b_out, video_on_out,
           cfg_ack, cfg_pending, collide, collide_valid
  );

  modport slave (
    input  tick, video_on, frame_start, on_in, r_in, g_in, b_in,
           cfg_req, cfg_en_mask, cfg_blink_mask, cfg_blink_period,
    output on_out, r_out, g_out, b_out, video_on_out,
           cfg_ack, cfg_pending, collide, collide_valid
  );
endinterface

// File: rtl/layer_compositor_ctrl.sv
// Per-pixel masking/registering front-end for the 8-layer compositor, with
// frame-synchronous configuration commit, layer blinking and player collision flags.
module layer_compositor_ctrl #(
  parameter int N_LAYERS     = 8,
  parameter int PLAYER_LAYER = 7,
  parameter int BLINK_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  layer_compositor_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [N_LAYERS-1:0] en;
    logic [N_LAYERS-1:0] blink;
    logic [BLINK_W-1:0]  period;
  } cfg_t;

  cfg_t                r_act, r_pend, w_cfg_in;
  logic                r_cfg_ack, r_cfg_pending, r_phase;
  logic [BLINK_W-1:0]  r_blink_cnt, w_period_m1;
  logic [N_LAYERS-1:0] r_on, r_r, r_g, r_b, r_acc, r_collide;
  logic [N_LAYERS-1:0] w_on_eff, w_hit;
  logic                r_video_on, r_collide_valid;
  logic                w_accept, w_commit, w_blink_wrap;

  // NOTE: every signal written in always_comb gets a default first, so no latch can form.
  always_comb begin
    w_cfg_in        = '0;
    w_cfg_in.en     = bus.cfg_en_mask;
    w_cfg_in.blink  = bus.cfg_blink_mask;
    w_cfg_in.period = bus.cfg_blink_period;

    w_accept     = bus.cfg_req & ~r_cfg_ack;
    w_commit     = bus.frame_start & (w_accept | r_cfg_pending);
    // Period 0 behaves as 1, so the wrap threshold saturates at 0.
    w_period_m1  = (r_act.period == '0) ? '0 : r_act.period - BLINK_W'(1);
    w_blink_wrap = (r_blink_cnt >= w_period_m1);

    w_on_eff = bus.on_in & r_act.en & ~(r_act.blink & {N_LAYERS{r_phase}});

    w_hit = '0;
    if (bus.tick && bus.video_on && w_on_eff[PLAYER_LAYER]) w_hit = w_on_eff;
    w_hit[PLAYER_LAYER] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_on       <= '0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
      r_video_on <= 1'b0;
    end else if (bus.tick) begin
      r_on       <= bus.video_on ? w_on_eff : '0;
      r_r        <= bus.video_on ? bus.r_in : '0;
      r_g        <= bus.video_on ? bus.g_in : '0;
      r_b        <= bus.video_on ? bus.b_in : '0;
      r_video_on <= bus.video_on;
    end
  end

  // Handshake, frame-boundary commit and blink sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act.en      <= '1;
      r_act.blink   <= '0;
      r_act.period  <= '0;
      r_pend        <= '0;
      r_cfg_ack     <= 1'b0;
      r_cfg_pending <= 1'b0;
      r_blink_cnt   <= '0;
      r_phase       <= 1'b0;
    end else begin
      r_cfg_ack <= w_accept;
      if (w_commit) begin
        r_act         <= w_accept ? w_cfg_in : r_pend;
        r_cfg_pending <= 1'b0;
        r_blink_cnt   <= '0;
        r_phase       <= 1'b0;
      end else begin
        if (w_accept) begin
          r_pend        <= w_cfg_in;
          r_cfg_pending <= 1'b1;
        end
        if (bus.frame_start) begin
          r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
          r_phase     <= r_phase ^ w_blink_wrap;
        end
      end
    end
  end

  // A hit landing in the frame_start cycle is folded into the reported flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc           <= '0;
      r_collide       <= '0;
      r_collide_valid <= 1'b0;
    end else begin
      r_collide_valid <= bus.frame_start;
      if (bus.frame_start) begin
        r_collide <= r_acc | w_hit;
        r_acc     <= '0;
      end else begin
        r_acc <= r_acc | w_hit;
      end
    end
  end

  assign bus.on_out        = r_on;
  assign bus.r_out         = r_r;
  assign bus.g_out         = r_g;
  assign bus.b_out         = r_b;
  assign bus.video_on_out  = r_video_on;
  assign bus.cfg_ack       = r_cfg_ack;
  assign bus.cfg_pending   = r_cfg_pending;
  assign bus.collide       = r_collide;
  assign bus.collide_valid = r_collide_valid;

endmodule
